dmem_mmu: RTL
=============

# dmem_mmu

Parametrised data-side memory management unit for the rv32i softcore: decodes load/store requests from the core's memory stage onto an on-chip RAM bank, a read-only ROM data port and N byte-addressed I/O channels. Performs sub-word alignment on stores and sign- or zero-extension on loads. Adds a valid/ready request handshake, variable-latency I/O with timeout, and fault reporting for unmapped, illegal or misaligned accesses. Sits between the core's memory stage and the memory/peripheral fabric; one access outstanding at a time.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; power of two, at least 4; `RAM_AW = $clog2(RAM_WORDS)`.
- `ROM_WORDS`, 1024: ROM depth in 32-bit words; power of two; `ROM_AW = $clog2(ROM_WORDS)`.
- `IO_CHANNELS`, 4: number of I/O channels, 1..16.
- `IO_TIMEOUT`, 15: maximum wait cycles for `io_ready` before a fault; 1..255.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit idle; request is accepted when `req_valid && req_ready`.
- `req_addr` in 32: byte address.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_signed` in 1: sign-extend load result.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `rsp_fault` out 1: access faulted; qualified by `rsp_valid`.
- `rom_addr` out ROM_AW: ROM word address; ROM read data returns one cycle later.
- `rom_data` in 32: ROM read data.
- `io_sel` out IO_CHANNELS: one-hot channel select, held for the whole transaction.
- `io_addr` out 8: byte offset within the channel.
- `io_we`, `io_be` out 1, 4: write strobe and byte enables.
- `io_wdata` out 32: lane-aligned store data.
- `io_rdata` in 32*IO_CHANNELS: channel k occupies bits [32k+31:32k].
- `io_ready` in IO_CHANNELS: channel k has completed the transaction.

## Operation
- **Address map**
  - ROM: 0x00000000 to ROM_WORDS*4-1. Read-only; a store here faults.
  - RAM: 0x10000000 to 0x10000000+RAM_WORDS*4-1.
  - I/O channel k: 0x80000000+k*0x100 to 0x800000FF+k*0x100, for k < IO_CHANNELS.
  - Any other address, or `req_size`=11, faults.
- **Byte enables**
  - Byte: 1 << addr[1:0].
  - Half: 0011 if addr[1]=0, else 1100.
  - Word: 1111.
- **Stores:** data is replicated or shifted so each enabled lane carries the correct bytes. RAM is written per enabled lane only.
- **Loads:** the selected lanes are extracted, then zero-extended, or sign-extended from bit 7 (byte) or bit 15 (half) when `req_signed`=1.
- **FSM states:**
  - IDLE: `req_ready`=1. On handshake:
    - Faulting request goes to RESP with fault set and no side effects.
    - RAM or ROM load goes to MEM.
    - RAM store writes the RAM on the accept edge, then goes to RESP.
    - I/O access goes to IOWAIT.
  - MEM: captures synchronous RAM/ROM read data; goes to RESP.
  - IOWAIT: holds `io_sel`, `io_addr`, `io_we`, `io_be`, `io_wdata` and counts wait cycles.
    - If `io_ready[k]`=1, capture `io_rdata` lane k and go to RESP.
    - If the counter equals IO_TIMEOUT with `io_ready[k]` still low, go to RESP with fault set.
  - RESP: `rsp_valid`=1 for one cycle, then back to IDLE.
- `io_ready` of unselected channels is ignored.
- `req_*` inputs are sampled only on the handshake; later changes have no effect.

## Timing
- **Reset values:** state IDLE. `req_ready`=1 from the first cycle after reset deasserts and 0 while `reset`=1. All other outputs are 0: `rsp_valid`, `rsp_rdata`, `rsp_fault`, `io_sel`, `io_we`, `io_be`, `io_addr`, `io_wdata`, `rom_addr`.
- **Latency from accept edge T:**
  - Fault or RAM store: `rsp_valid` in cycle T+1.
  - RAM/ROM load: `rsp_valid` in cycle T+2.
  - I/O: `io_sel` is high from T+1. If `io_ready` is first sampled high at T+1+n, `rsp_valid` is at T+2+n.
  - I/O timeout: `rsp_valid` at T+2+IO_TIMEOUT with fault set.
- **Throughput:** the next accept is possible in the cycle after RESP.
- **Reset mid-transaction:** the access is abandoned, `io_sel` drops on the next edge, and no response is issued.
- **No response backpressure:** the consumer must take `rsp_valid` in the cycle it is high.

## Configuration
- `MMU_MISALIGN_TRAP_EN`
  - Defined: a half access with addr[0]=1, or a word access with addr[1:0]≠00, faults with no side effects.
  - Undefined: misaligned low address bits are ignored. Half uses only addr[1]; word forces 1111 at the aligned word. No fault is raised for misalignment.

## Structure
- Package `mmu_pkg`:
  - Region base constants: ROM_BASE, RAM_BASE, IO_BASE, IO_STRIDE=0x100.
  - Size encodings: SZ_BYTE, SZ_HALF, SZ_WORD.
  - FSM state enum.
  - Decoded-device enum: DEV_ROM, DEV_RAM, DEV_IO, DEV_NONE.
- Sub-module `mmu_lane_align`: combinational store byte-enable/shift and load extract/extend, instantiated once for each direction.
- RAM is built as four 8-bit byte-lane synchronous single-port BRAMs.

## Test plan
- Store word 0xDEADBEEF to 0x10000004, then lbu at 0x10000007 returns 0x000000DE and lh at 0x10000004 returns 0xFFFFBEEF; each load's `rsp_valid` is 2 cycles after accept.
- Store byte 0x80 to 0x10000001 over prior word 0x11223344, then lw returns 0x11228044 (only lane 1 is written).
- I/O load at 0x80000104 with `io_ready[1]` raised 3 cycles after `io_sel`=0010: `rsp_rdata` equals `io_rdata` lane 1, no fault; `io_ready[0]` toggling meanwhile is ignored.
- I/O store with `io_ready` held low, IO_TIMEOUT=15: `rsp_fault`=1 at accept+17; store to 0x00000010 (ROM) faults at accept+1.
- With `MMU_MISALIGN_TRAP_EN`: lw at 0x10000002 faults and RAM is unchanged. Without it: the same lw returns the word at 0x10000000.
- Assert `reset` during IOWAIT: `io_sel`=0 and state IDLE after the next edge, no `rsp_valid`; a fresh request is then accepted normally.

Source files
------------

// File: rtl/mmu_pkg.sv
// Purpose: shared address map, size encodings and enums for the dmem_mmu data-side MMU.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Ports: none.
package mmu_pkg;

  // Region bases; each region's extent depends on the top-level parameters.
  localparam logic [31:0] ROM_BASE  = 32'h0000_0000;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] IO_BASE   = 32'h8000_0000;
  localparam logic [31:0] IO_STRIDE = 32'h0000_0100;

  // req_size encodings; 2'b11 is illegal and faults.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM    = 2'd1,
    ST_IOWAIT = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    DEV_ROM  = 2'd0,
    DEV_RAM  = 2'd1,
    DEV_IO   = 2'd2,
    DEV_NONE = 2'd3
  } dev_e;

endpackage

// File: rtl/mmu_lane_align.sv
// Purpose: byte-lane alignment: store byte enables + lane replication, load extract + extension.
// Latency: combinational.
// Backpressure: none.
// Ports: size/off/sgn/din in; be, st_data (lane-aligned store data), ld_data (extended load data) out.
// Misaligned low bits are ignored here: half uses only off[1], word always enables all lanes.
module mmu_lane_align
  import mmu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic        sgn,
  input  logic [31:0] din,
  output logic [3:0]  be,
  output logic [31:0] st_data,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    be      = 4'b1111;
    st_data = din;
    ld_data = din;
    ld_byte = din[{off, 3'b000} +: 8];
    ld_half = off[1] ? din[31:16] : din[15:0];
    case (size)
      SZ_BYTE: begin
        be      = 4'b0001 << off;
        // Replicating the byte puts it on every lane; be picks the real one.
        st_data = {4{din[7:0]}};
        ld_data = {{24{sgn & ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        be      = off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{din[15:0]}};
        ld_data = {{16{sgn & ld_half[15]}}, ld_half};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_mmu.sv
// Purpose: rv32i data-side MMU decoding loads/stores onto on-chip RAM, ROM data port and N I/O channels.
// Latency: fault/RAM store 1 cycle, RAM/ROM load 2 cycles, I/O 2+wait cycles (timeout after IO_TIMEOUT waits).
// Backpressure: req_ready low while an access is outstanding; responses cannot be stalled.
// Ports: clk/reset; req_* valid/ready request; rsp_* one-cycle response; rom_addr/rom_data ROM port;
//        io_sel/io_addr/io_we/io_be/io_wdata held during an I/O access, io_rdata/io_ready per channel.
// Build option: MMU_MISALIGN_TRAP_EN makes misaligned half/word accesses fault.
module dmem_mmu
  import mmu_pkg::*;
#(
  parameter int  RAM_WORDS   = 1024,
  parameter int  ROM_WORDS   = 1024,
  parameter int  IO_CHANNELS = 4,
  parameter int  IO_TIMEOUT  = 15,
  localparam int RAM_AW      = $clog2(RAM_WORDS),
  localparam int ROM_AW      = $clog2(ROM_WORDS)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [31:0]                req_addr,
  input  logic                       req_we,
  input  logic [1:0]                 req_size,
  input  logic                       req_signed,
  input  logic [31:0]                req_wdata,
  output logic                       rsp_valid,
  output logic [31:0]                rsp_rdata,
  output logic                       rsp_fault,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [31:0]                rom_data,
  output logic [IO_CHANNELS-1:0]     io_sel,
  output logic [7:0]                 io_addr,
  output logic                       io_we,
  output logic [3:0]                 io_be,
  output logic [31:0]                io_wdata,
  input  logic [32*IO_CHANNELS-1:0]  io_rdata,
  input  logic [IO_CHANNELS-1:0]     io_ready
);

  localparam logic [31:0] ROM_BYTES = 32'(ROM_WORDS) << 2;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;
  localparam logic [31:0] IO_BYTES  = 32'(IO_CHANNELS) * IO_STRIDE;
  localparam logic [7:0]  TMO       = 8'(IO_TIMEOUT);

  state_e                 state_q, state_d;
  dev_e                   dev_q, dev_d;
  logic [1:0]             size_q, size_d;
  logic [1:0]             off_q, off_d;
  logic                   sgn_q, sgn_d;
  logic                   we_q, we_d;
  logic [3:0]             chan_q, chan_d;
  logic [7:0]             wait_q, wait_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   rsp_fault_q, rsp_fault_d;
  logic [31:0]            rsp_rdata_q, rsp_rdata_d;
  logic [IO_CHANNELS-1:0] io_sel_q, io_sel_d;
  logic [7:0]             io_addr_q, io_addr_d;
  logic                   io_we_q, io_we_d;
  logic [3:0]             io_be_q, io_be_d;
  logic [31:0]            io_wdata_q, io_wdata_d;

  // ---------------- request decode ----------------
  logic [31:0]            rom_off, ram_off, io_off;
  dev_e                   req_dev;
  logic                   misalign, req_fault, accept;
  logic [IO_CHANNELS-1:0] io_sel_dec;

  // Offsets relative to each base; an unsigned compare against the region
  // size also rejects addresses below the base through wrap-around.
  assign rom_off = req_addr - ROM_BASE;
  assign ram_off = req_addr - RAM_BASE;
  assign io_off  = req_addr - IO_BASE;

  always_comb begin
    if (rom_off < ROM_BYTES)      req_dev = DEV_ROM;
    else if (ram_off < RAM_BYTES) req_dev = DEV_RAM;
    else if (io_off < IO_BYTES)   req_dev = DEV_IO;
    else                          req_dev = DEV_NONE;
  end

  always_comb begin
    io_sel_dec = '0;
    for (int k = 0; k < IO_CHANNELS; k++) begin
      io_sel_dec[k] = (io_off[11:8] == 4'(k));
    end
  end

`ifdef MMU_MISALIGN_TRAP_EN
  assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                    ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_ready = (state_q == ST_IDLE) && !reset;
  assign accept    = req_valid && req_ready;
  assign req_fault = (req_dev == DEV_NONE) || (req_size == 2'b11) ||
                     ((req_dev == DEV_ROM) && req_we) || misalign;

  // ---------------- lane alignment ----------------
  logic [3:0]  st_be;
  logic [31:0] st_data, st_ld_unused;
  logic [31:0] ld_din, ld_data, ld_st_unused;
  logic [3:0]  ld_be_unused;

  // Store side works on the live request so RAM can be written on the accept edge.
  mmu_lane_align u_store_align (
    .size    (req_size),
    .off     (req_addr[1:0]),
    .sgn     (req_signed),
    .din     (req_wdata),
    .be      (st_be),
    .st_data (st_data),
    .ld_data (st_ld_unused)
  );

  // Load side works on the captured request fields and the returning data.
  mmu_lane_align u_load_align (
    .size    (size_q),
    .off     (off_q),
    .sgn     (sgn_q),
    .din     (ld_din),
    .be      (ld_be_unused),
    .st_data (ld_st_unused),
    .ld_data (ld_data)
  );

  // ---------------- RAM: four byte-lane synchronous BRAMs ----------------
  logic              ram_we, ram_re;
  logic [RAM_AW-1:0] ram_idx;
  logic [31:0]       ram_rdata;

  assign ram_idx = ram_off[RAM_AW+1:2];
  assign ram_we  = accept && !req_fault && (req_dev == DEV_RAM) && req_we;
  assign ram_re  = accept && !req_fault && (req_dev == DEV_RAM) && !req_we;

  for (genvar g = 0; g < 4; g++) begin : g_ram_lane
    logic [7:0] mem [RAM_WORDS];
    logic [7:0] rd_q;
    always_ff @(posedge clk) begin
      if (ram_we && st_be[g]) mem[ram_idx] <= st_data[8*g +: 8];
      if (ram_re)             rd_q <= mem[ram_idx];
    end
    assign ram_rdata[8*g +: 8] = rd_q;
  end

  // ROM samples the address on the accept edge, so it is driven straight
  // from the request while idle; data is back during ST_MEM.
  assign rom_addr = ((state_q == ST_IDLE) && req_valid && !reset) ? rom_off[ROM_AW+1:2] : '0;

  // ---------------- I/O channel return mux ----------------
  logic [31:0] io_lane;
  logic        io_rdy;

  always_comb begin
    io_lane = '0;
    io_rdy  = 1'b0;
    for (int k = 0; k < IO_CHANNELS; k++) begin
      if (chan_q == 4'(k)) begin
        io_lane = io_rdata[32*k +: 32];
        io_rdy  = io_ready[k];
      end
    end
  end

  assign ld_din = (state_q == ST_IOWAIT) ? io_lane :
                  (dev_q == DEV_RAM)     ? ram_rdata : rom_data;

  // ---------------- FSM next state ----------------
  always_comb begin
    state_d     = state_q;
    dev_d       = dev_q;
    size_d      = size_q;
    off_d       = off_q;
    sgn_d       = sgn_q;
    we_d        = we_q;
    chan_d      = chan_q;
    wait_d      = wait_q;
    rsp_valid_d = 1'b0;
    rsp_fault_d = 1'b0;
    rsp_rdata_d = '0;
    io_sel_d    = '0;
    io_addr_d   = '0;
    io_we_d     = 1'b0;
    io_be_d     = '0;
    io_wdata_d  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          dev_d  = req_dev;
          size_d = req_size;
          off_d  = req_addr[1:0];
          sgn_d  = req_signed;
          we_d   = req_we;
          chan_d = io_off[11:8];
          wait_d = '0;
          if (req_fault) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
            rsp_fault_d = 1'b1;
          end else if (req_dev == DEV_IO) begin
            state_d    = ST_IOWAIT;
            io_sel_d   = io_sel_dec;
            io_addr_d  = io_off[7:0];
            io_we_d    = req_we;
            io_be_d    = st_be;
            io_wdata_d = st_data;
          end else if (req_we) begin
            state_d     = ST_RESP;
            rsp_valid_d = 1'b1;
          end else begin
            state_d = ST_MEM;
          end
        end
      end
      ST_MEM: begin
        state_d     = ST_RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = ld_data;
      end
      ST_IOWAIT: begin
        if (io_rdy) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = we_q ? 32'h0 : ld_data;
        end else if (wait_q == TMO) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          rsp_fault_d = 1'b1;
        end else begin
          wait_d     = wait_q + 8'd1;
          io_sel_d   = io_sel_q;
          io_addr_d  = io_addr_q;
          io_we_d    = io_we_q;
          io_be_d    = io_be_q;
          io_wdata_d = io_wdata_q;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- state and registered outputs ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      dev_q       <= DEV_NONE;
      size_q      <= '0;
      off_q       <= '0;
      sgn_q       <= 1'b0;
      we_q        <= 1'b0;
      chan_q      <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
      io_sel_q    <= '0;
      io_addr_q   <= '0;
      io_we_q     <= 1'b0;
      io_be_q     <= '0;
      io_wdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      dev_q       <= dev_d;
      size_q      <= size_d;
      off_q       <= off_d;
      sgn_q       <= sgn_d;
      we_q        <= we_d;
      chan_q      <= chan_d;
      wait_q      <= wait_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_fault_q <= rsp_fault_d;
      rsp_rdata_q <= rsp_rdata_d;
      io_sel_q    <= io_sel_d;
      io_addr_q   <= io_addr_d;
      io_we_q     <= io_we_d;
      io_be_q     <= io_be_d;
      io_wdata_q  <= io_wdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_fault = rsp_fault_q;
  assign rsp_rdata = rsp_rdata_q;
  assign io_sel    = io_sel_q;
  assign io_addr   = io_addr_q;
  assign io_we     = io_we_q;
  assign io_be     = io_be_q;
  assign io_wdata  = io_wdata_q;

endmodule
